// File: rtl/rvfi_seq_pkg.sv
//------------------------------------------------------------------------------
// rvfi_seq_pkg
//   Shared types for the RVFI check sequencer: the FSM state encoding and a
//   packed record holding one single-channel RVFI retirement.
//   Field widths follow RISCV_FORMAL_XLEN / RISCV_FORMAL_ILEN, which default
//   to 32 when the formal framework has not defined them.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif
`ifndef RISCV_FORMAL_ILEN
`define RISCV_FORMAL_ILEN 32
`endif

package rvfi_seq_pkg;

  localparam int RVFI_XLEN = `RISCV_FORMAL_XLEN;
  localparam int RVFI_ILEN = `RISCV_FORMAL_ILEN;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic                   valid;
    logic [63:0]            order;
    logic [RVFI_ILEN-1:0]   insn;
    logic                   trap;
    logic                   halt;
    logic                   intr;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [RVFI_XLEN-1:0]   rs1_rdata;
    logic [RVFI_XLEN-1:0]   rs2_rdata;
    logic [4:0]             rd_addr;
    logic [RVFI_XLEN-1:0]   rd_wdata;
    logic [RVFI_XLEN-1:0]   pc_rdata;
    logic [RVFI_XLEN-1:0]   pc_wdata;
    logic [RVFI_XLEN-1:0]   mem_addr;
    logic [RVFI_XLEN/8-1:0] mem_rmask;
    logic [RVFI_XLEN/8-1:0] mem_wmask;
    logic [RVFI_XLEN-1:0]   mem_rdata;
    logic [RVFI_XLEN-1:0]   mem_wdata;
  } rvfi_rec_t;

endpackage

`default_nettype wire

// File: rtl/rvfi_order_monitor.sv
//------------------------------------------------------------------------------
// rvfi_order_monitor
//   Tracks rvfi_order continuity. Each valid retirement must carry the order
//   following the previous one (modulo 2^64, first expected order is 0); any
//   gap or repeat sets a sticky error flag one cycle later.
//   Ports:
//     clock, resetn  - clock, synchronous active-low reset
//     valid, order   - RVFI valid / order of the observed channel
//     order_err      - sticky discontinuity flag
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rvfi_order_monitor (
  input  logic        clock,
  input  logic        resetn,
  input  logic        valid,
  input  logic [63:0] order,
  output logic        order_err
);

  logic [63:0] exp_order;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      exp_order <= 64'd0;
      order_err <= 1'b0;
    end else if (valid) begin
      if (order != exp_order) begin
        order_err <= 1'b1;
      end
      // Natural 64-bit wrap makes 2^64-1 -> 0 a legal step.
      exp_order <= order + 64'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rvfi_check_sequencer.sv
//------------------------------------------------------------------------------
// rvfi_check_sequencer
//   Single-channel RVFI capture stage in front of a per-instruction checker.
//   Counts cycles after reset, captures the first retirement at or after
//   CHECK_CYCLE, holds it on out_* and pulses check for one cycle.
//   Ports:
//     clock, resetn  - clock, synchronous active-low reset
//     in_*           - live single-channel RVFI fields
//     out_*          - held copy of the selected retirement
//     check          - one-cycle pulse, out_* valid while high
//     order_err      - sticky rvfi_order discontinuity flag
//     timeout        - sticky "no retirement in window" flag
//   Configuration macro: RISCV_FORMAL_CHECK_TIMEOUT_EN enables the timeout
//   counter and the timeout port; without it ARMED waits indefinitely.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rvfi_check_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ILEN        = 32,
  parameter int CHECK_CYCLE = 20,
  parameter int TIMEOUT     = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [63:0]       in_order,
  input  logic [ILEN-1:0]   in_insn,
  input  logic              in_trap,
  input  logic              in_halt,
  input  logic              in_intr,
  input  logic [4:0]        in_rs1_addr,
  input  logic [4:0]        in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_rdata,
  input  logic [XLEN-1:0]   in_rs2_rdata,
  input  logic [4:0]        in_rd_addr,
  input  logic [XLEN-1:0]   in_rd_wdata,
  input  logic [XLEN-1:0]   in_pc_rdata,
  input  logic [XLEN-1:0]   in_pc_wdata,
  input  logic [XLEN-1:0]   in_mem_addr,
  input  logic [XLEN/8-1:0] in_mem_rmask,
  input  logic [XLEN/8-1:0] in_mem_wmask,
  input  logic [XLEN-1:0]   in_mem_rdata,
  input  logic [XLEN-1:0]   in_mem_wdata,
  output logic              out_valid,
  output logic [63:0]       out_order,
  output logic [ILEN-1:0]   out_insn,
  output logic              out_trap,
  output logic              out_halt,
  output logic              out_intr,
  output logic [4:0]        out_rs1_addr,
  output logic [4:0]        out_rs2_addr,
  output logic [XLEN-1:0]   out_rs1_rdata,
  output logic [XLEN-1:0]   out_rs2_rdata,
  output logic [4:0]        out_rd_addr,
  output logic [XLEN-1:0]   out_rd_wdata,
  output logic [XLEN-1:0]   out_pc_rdata,
  output logic [XLEN-1:0]   out_pc_wdata,
  output logic [XLEN-1:0]   out_mem_addr,
  output logic [XLEN/8-1:0] out_mem_rmask,
  output logic [XLEN/8-1:0] out_mem_wmask,
  output logic [XLEN-1:0]   out_mem_rdata,
  output logic [XLEN-1:0]   out_mem_wdata,
  output logic              check,
`ifdef RISCV_FORMAL_CHECK_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic              order_err
);

  localparam int CYC_W = $clog2(CHECK_CYCLE + TIMEOUT + 2);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;
  // Cycle on which WAIT hands over to ARMED (unused when CHECK_CYCLE == 0).
  localparam logic [CYC_W-1:0] ARM_AT  = CYC_W'((CHECK_CYCLE > 0) ? CHECK_CYCLE - 1 : 0);

  logic [CYC_W-1:0] cyc;
  seq_state_t       state;
  rvfi_rec_t        in_rec;
  rvfi_rec_t        out_rec;

  always_comb begin
    in_rec           = '0;
    in_rec.valid     = in_valid;
    in_rec.order     = in_order;
    in_rec.insn      = in_insn;
    in_rec.trap      = in_trap;
    in_rec.halt      = in_halt;
    in_rec.intr      = in_intr;
    in_rec.rs1_addr  = in_rs1_addr;
    in_rec.rs2_addr  = in_rs2_addr;
    in_rec.rs1_rdata = in_rs1_rdata;
    in_rec.rs2_rdata = in_rs2_rdata;
    in_rec.rd_addr   = in_rd_addr;
    in_rec.rd_wdata  = in_rd_wdata;
    in_rec.pc_rdata  = in_pc_rdata;
    in_rec.pc_wdata  = in_pc_wdata;
    in_rec.mem_addr  = in_mem_addr;
    in_rec.mem_rmask = in_mem_rmask;
    in_rec.mem_wmask = in_mem_wmask;
    in_rec.mem_rdata = in_mem_rdata;
    in_rec.mem_wdata = in_mem_wdata;
  end

  // Free-running cycle counter, saturating so it never re-opens the window.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cyc <= '0;
    end else if (cyc != CYC_MAX) begin
      cyc <= cyc + CYC_W'(1);
    end
  end

`ifdef RISCV_FORMAL_CHECK_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Last ARMED cycle that may still capture; timing out happens on its edge.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  logic [TMO_W-1:0] tcnt;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      // With no waiting period the window is open from the first cycle.
      if (CHECK_CYCLE == 0) begin
        state <= ARMED;
      end else begin
        state <= WAIT;
      end
      check   <= 1'b0;
      out_rec <= '0;
`ifdef RISCV_FORMAL_CHECK_TIMEOUT_EN
      tcnt    <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      case (state)
        WAIT: begin
          if (cyc == ARM_AT) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (in_valid) begin
            out_rec <= in_rec;
            check   <= 1'b1;
            state   <= FIRE;
          end
`ifdef RISCV_FORMAL_CHECK_TIMEOUT_EN
          else if (tcnt == TMO_LAST) begin
            timeout <= 1'b1;
            state   <= DONE;
          end else begin
            tcnt <= tcnt + TMO_W'(1);
          end
`endif
        end
        FIRE: begin
          check <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          check <= 1'b0;
        end
        default: begin
          state <= WAIT;
        end
      endcase
    end
  end

  rvfi_order_monitor u_order_monitor (
    .clock     (clock),
    .resetn    (resetn),
    .valid     (in_valid),
    .order     (in_order),
    .order_err (order_err)
  );

  assign out_valid     = out_rec.valid;
  assign out_order     = out_rec.order;
  assign out_insn      = out_rec.insn;
  assign out_trap      = out_rec.trap;
  assign out_halt      = out_rec.halt;
  assign out_intr      = out_rec.intr;
  assign out_rs1_addr  = out_rec.rs1_addr;
  assign out_rs2_addr  = out_rec.rs2_addr;
  assign out_rs1_rdata = out_rec.rs1_rdata;
  assign out_rs2_rdata = out_rec.rs2_rdata;
  assign out_rd_addr   = out_rec.rd_addr;
  assign out_rd_wdata  = out_rec.rd_wdata;
  assign out_pc_rdata  = out_rec.pc_rdata;
  assign out_pc_wdata  = out_rec.pc_wdata;
  assign out_mem_addr  = out_rec.mem_addr;
  assign out_mem_rmask = out_rec.mem_rmask;
  assign out_mem_wmask = out_rec.mem_wmask;
  assign out_mem_rdata = out_rec.mem_rdata;
  assign out_mem_wdata = out_rec.mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_rvfi_check_sequencer.sv
//------------------------------------------------------------------------------
// tb_rvfi_check_sequencer
//   Directed bench. Two instances share the RVFI input stimulus:
//     dut   - CHECK_CYCLE=5, TIMEOUT=4
//     dut0  - CHECK_CYCLE=0
//   Cycle k is the interval in which cyc == k; inputs for cycle k are driven
//   at the negedge opening it, outputs are sampled at that same negedge
//   before driving.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rvfi_check_sequencer;
  import rvfi_seq_pkg::*;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic [63:0] in_order;
  logic [31:0] in_insn;
  logic        in_trap, in_halt, in_intr;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_rdata, in_rs2_rdata, in_rd_wdata;
  logic [31:0] in_pc_rdata, in_pc_wdata, in_mem_addr, in_mem_rdata, in_mem_wdata;
  logic [3:0]  in_mem_rmask, in_mem_wmask;

  logic        a_valid, a_trap, a_halt, a_intr, a_check, a_order_err;
  logic [63:0] a_order;
  logic [31:0] a_insn, a_rs1_rdata, a_rs2_rdata, a_rd_wdata, a_pc_rdata, a_pc_wdata;
  logic [31:0] a_mem_addr, a_mem_rdata, a_mem_wdata;
  logic [4:0]  a_rs1_addr, a_rs2_addr, a_rd_addr;
  logic [3:0]  a_mem_rmask, a_mem_wmask;
  logic        b_valid, b_trap, b_halt, b_intr, b_check, b_order_err;
  logic [63:0] b_order;
  logic [31:0] b_insn, b_rs1_rdata, b_rs2_rdata, b_rd_wdata, b_pc_rdata, b_pc_wdata;
  logic [31:0] b_mem_addr, b_mem_rdata, b_mem_wdata;
  logic [4:0]  b_rs1_addr, b_rs2_addr, b_rd_addr;
  logic [3:0]  b_mem_rmask, b_mem_wmask;
`ifdef RISCV_FORMAL_CHECK_TIMEOUT_EN
  logic        a_timeout, b_timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rvfi_check_sequencer #(.XLEN(32), .ILEN(32), .CHECK_CYCLE(5), .TIMEOUT(4)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn),
    .in_trap(in_trap), .in_halt(in_halt), .in_intr(in_intr),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_rdata(in_rs1_rdata), .in_rs2_rdata(in_rs2_rdata),
    .in_rd_addr(in_rd_addr), .in_rd_wdata(in_rd_wdata),
    .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_mem_addr(in_mem_addr), .in_mem_rmask(in_mem_rmask), .in_mem_wmask(in_mem_wmask),
    .in_mem_rdata(in_mem_rdata), .in_mem_wdata(in_mem_wdata),
    .out_valid(a_valid), .out_order(a_order), .out_insn(a_insn),
    .out_trap(a_trap), .out_halt(a_halt), .out_intr(a_intr),
    .out_rs1_addr(a_rs1_addr), .out_rs2_addr(a_rs2_addr),
    .out_rs1_rdata(a_rs1_rdata), .out_rs2_rdata(a_rs2_rdata),
    .out_rd_addr(a_rd_addr), .out_rd_wdata(a_rd_wdata),
    .out_pc_rdata(a_pc_rdata), .out_pc_wdata(a_pc_wdata),
    .out_mem_addr(a_mem_addr), .out_mem_rmask(a_mem_rmask), .out_mem_wmask(a_mem_wmask),
    .out_mem_rdata(a_mem_rdata), .out_mem_wdata(a_mem_wdata),
    .check(a_check),
`ifdef RISCV_FORMAL_CHECK_TIMEOUT_EN
    .timeout(a_timeout),
`endif
    .order_err(a_order_err)
  );

  rvfi_check_sequencer #(.XLEN(32), .ILEN(32), .CHECK_CYCLE(0), .TIMEOUT(4)) dut0 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn),
    .in_trap(in_trap), .in_halt(in_halt), .in_intr(in_intr),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_rdata(in_rs1_rdata), .in_rs2_rdata(in_rs2_rdata),
    .in_rd_addr(in_rd_addr), .in_rd_wdata(in_rd_wdata),
    .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
    .in_mem_addr(in_mem_addr), .in_mem_rmask(in_mem_rmask), .in_mem_wmask(in_mem_wmask),
    .in_mem_rdata(in_mem_rdata), .in_mem_wdata(in_mem_wdata),
    .out_valid(b_valid), .out_order(b_order), .out_insn(b_insn),
    .out_trap(b_trap), .out_halt(b_halt), .out_intr(b_intr),
    .out_rs1_addr(b_rs1_addr), .out_rs2_addr(b_rs2_addr),
    .out_rs1_rdata(b_rs1_rdata), .out_rs2_rdata(b_rs2_rdata),
    .out_rd_addr(b_rd_addr), .out_rd_wdata(b_rd_wdata),
    .out_pc_rdata(b_pc_rdata), .out_pc_wdata(b_pc_wdata),
    .out_mem_addr(b_mem_addr), .out_mem_rmask(b_mem_rmask), .out_mem_wmask(b_mem_wmask),
    .out_mem_rdata(b_mem_rdata), .out_mem_wdata(b_mem_wdata),
    .check(b_check),
`ifdef RISCV_FORMAL_CHECK_TIMEOUT_EN
    .timeout(b_timeout),
`endif
    .order_err(b_order_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // Drive one retirement; payload fields are derived from the order so the
  // held copy can be recognised: pc = 0x1000 + 4*order, insn = 0x13 | order<<16,
  // rd_wdata = 0xA5A50000 | order[15:0].
  task automatic drive(input bit v, input logic [63:0] ord, input bit trap);
    in_valid     = v;
    in_order     = ord;
    in_insn      = 32'h0000_0013 | {ord[15:0], 16'h0000};
    in_trap      = trap;
    in_halt      = 1'b0;
    in_intr      = 1'b0;
    in_rs1_addr  = 5'd1;
    in_rs2_addr  = 5'd2;
    in_rd_addr   = 5'd3;
    in_rs1_rdata = 32'h1111_0000 | {16'h0, ord[15:0]};
    in_rs2_rdata = 32'h2222_0000 | {16'h0, ord[15:0]};
    in_rd_wdata  = 32'hA5A5_0000 | {16'h0, ord[15:0]};
    in_pc_rdata  = 32'h0000_1000 + {ord[29:0], 2'b00};
    in_pc_wdata  = 32'h0000_1004 + {ord[29:0], 2'b00};
    in_mem_addr  = 32'h8000_0000 | ord[31:0];
    in_mem_rmask = 4'hF;
    in_mem_wmask = 4'h0;
    in_mem_rdata = 32'hDEAD_0000 | {16'h0, ord[15:0]};
    in_mem_wdata = 32'h0;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Leaves the bench at the negedge opening cycle 0.
  task automatic reset_dut();
    resetn = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    n_tests++; if (a_check !== 1'b0) begin n_fail++; $display("FAIL reset_check: got %b required 0", a_check); end
    n_tests++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", a_valid); end
    n_tests++; if (a_order !== 64'd0 || a_pc_rdata !== 32'd0 || a_insn !== 32'd0)
      begin n_fail++; $display("FAIL reset_out_fields: got order %h pc %h insn %h required 0", a_order, a_pc_rdata, a_insn); end
    n_tests++; if (a_order_err !== 1'b0) begin n_fail++; $display("FAIL reset_order_err: got %b required 0", a_order_err); end
    n_tests++; if (dut.state !== WAIT) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", dut.state, WAIT); end
    n_tests++; if (dut.cyc !== '0) begin n_fail++; $display("FAIL reset_cyc: got %0d required 0", dut.cyc); end
  endtask

  // CHECK_CYCLE=5: valid at 3 (WAIT), 6 and 7 with orders 0,1,2.
  task automatic test_capture();
    logic exp_chk;
    reset_dut();
    for (int k = 0; k < 12; k++) begin
      exp_chk = (k == 7);
      n_tests++;
      if (a_check !== exp_chk) begin n_fail++; $display("FAIL capture_check_c%0d: got %b required %b", k, a_check, exp_chk); end
      if (k == 7) begin
        n_tests++; if (a_valid !== 1'b1 || a_order !== 64'd1)
          begin n_fail++; $display("FAIL capture_order: got valid %b order %0d required 1/1", a_valid, a_order); end
        n_tests++; if (a_pc_rdata !== 32'h0000_1004 || a_insn !== 32'h0001_0013 || a_pc_wdata !== 32'h0000_1008)
          begin n_fail++; $display("FAIL capture_fields: got pc %h insn %h pcw %h required 00001004 00010013 00001008", a_pc_rdata, a_insn, a_pc_wdata); end
      end
      case (k)
        3:       drive(1'b1, 64'd0, 1'b0);
        6:       drive(1'b1, 64'd1, 1'b0);
        7:       drive(1'b1, 64'd2, 1'b0);
        default: drive(1'b0, 64'd0, 1'b0);
      endcase
      tick();
    end
    n_tests++; if (a_order !== 64'd1 || a_rd_wdata !== 32'hA5A5_0001 || a_mem_rdata !== 32'hDEAD_0001)
      begin n_fail++; $display("FAIL capture_hold: got order %0d rd %h mem %h required 1 a5a50001 dead0001", a_order, a_rd_wdata, a_mem_rdata); end
    n_tests++; if (a_order_err !== 1'b0) begin n_fail++; $display("FAIL capture_order_err: got %b required 0", a_order_err); end
    n_tests++; if (dut.state !== DONE) begin n_fail++; $display("FAIL capture_state: got %0d required %0d", dut.state, DONE); end
  endtask

  // Valid on the WAIT->ARMED cycle (4) is skipped; the one at 5 is taken.
  task automatic test_window_edge();
    reset_dut();
    for (int k = 0; k < 7; k++) begin
      if (k == 5) begin
        n_tests++; if (a_check !== 1'b0) begin n_fail++; $display("FAIL edge_no_capture: got %b required 0", a_check); end
      end
      if (k == 6) begin
        n_tests++; if (a_check !== 1'b1 || a_order !== 64'd1)
          begin n_fail++; $display("FAIL edge_capture: got check %b order %0d required 1/1", a_check, a_order); end
      end
      case (k)
        4:       drive(1'b1, 64'd0, 1'b0);
        5:       drive(1'b1, 64'd1, 1'b0);
        default: drive(1'b0, 64'd0, 1'b0);
      endcase
      tick();
    end
  endtask

  task automatic test_order_err();
    reset_dut();
    for (int k = 0; k < 7; k++) begin
      if (k == 2 || k == 3 || k == 6) begin
        n_tests++;
        if (a_order_err !== (k != 2))
          begin n_fail++; $display("FAIL order_err_c%0d: got %b required %b", k, a_order_err, (k != 2)); end
      end
      case (k)
        0:       drive(1'b1, 64'd0, 1'b0);
        1:       drive(1'b1, 64'd1, 1'b0);
        2:       drive(1'b1, 64'd3, 1'b0);
        default: drive(1'b0, 64'd0, 1'b0);
      endcase
      tick();
    end
  endtask

  task automatic test_order_wrap();
    reset_dut();
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    tick();
    n_tests++; if (dut.u_order_monitor.exp_order !== 64'd0)
      begin n_fail++; $display("FAIL wrap_exp_order: got %h required 0", dut.u_order_monitor.exp_order); end
    // First retirement after reset must be order 0, so this one is flagged.
    n_tests++; if (a_order_err !== 1'b1) begin n_fail++; $display("FAIL wrap_first_err: got %b required 1", a_order_err); end
    drive(1'b1, 64'd0, 1'b0);
    tick();
    n_tests++; if (dut.u_order_monitor.exp_order !== 64'd1)
      begin n_fail++; $display("FAIL wrap_next: got %h required 1", dut.u_order_monitor.exp_order); end
    drive(1'b0, 64'd0, 1'b0);
  endtask

  task automatic test_reset_in_fire();
    reset_dut();
    for (int k = 0; k < 7; k++) begin
      drive((k == 6), 64'd0, 1'b0);
      tick();
    end
    n_tests++; if (a_check !== 1'b1) begin n_fail++; $display("FAIL fire_reached: got %b required 1", a_check); end
    resetn = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    tick();
    n_tests++; if (a_check !== 1'b0 || a_valid !== 1'b0 || a_order_err !== 1'b0)
      begin n_fail++; $display("FAIL fire_reset_flags: got check %b valid %b err %b required 0", a_check, a_valid, a_order_err); end
    n_tests++; if (a_pc_rdata !== 32'd0 || a_insn !== 32'd0 || a_mem_addr !== 32'd0)
      begin n_fail++; $display("FAIL fire_reset_fields: got pc %h insn %h addr %h required 0", a_pc_rdata, a_insn, a_mem_addr); end
    n_tests++; if (dut.state !== WAIT) begin n_fail++; $display("FAIL fire_reset_state: got %0d required %0d", dut.state, WAIT); end
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++; if (a_check !== 1'b0) begin n_fail++; $display("FAIL fire_no_pulse_c%0d: got %b required 0", k, a_check); end
    end
  endtask

  // CHECK_CYCLE=0 instance: a trap retirement in cycle 0 is captured.
  task automatic test_cc0_trap();
    reset_dut();
    n_tests++; if (b_check !== 1'b0) begin n_fail++; $display("FAIL cc0_idle: got %b required 0", b_check); end
    drive(1'b1, 64'd0, 1'b1);
    tick();
    n_tests++; if (b_check !== 1'b1 || b_trap !== 1'b1 || b_valid !== 1'b1)
      begin n_fail++; $display("FAIL cc0_capture: got check %b trap %b valid %b required 1/1/1", b_check, b_trap, b_valid); end
    drive(1'b0, 64'd0, 1'b0);
    tick();
    n_tests++; if (b_check !== 1'b0 || b_trap !== 1'b1)
      begin n_fail++; $display("FAIL cc0_after: got check %b trap %b required 0/1", b_check, b_trap); end
  endtask

`ifdef RISCV_FORMAL_CHECK_TIMEOUT_EN
  task automatic test_timeout();
    logic seen;
    seen = 1'b0;
    reset_dut();
    for (int k = 0; k < 14; k++) begin
      seen = seen | a_check;
      if (k == 8 || k == 9) begin
        n_tests++; if (a_timeout !== (k == 9))
          begin n_fail++; $display("FAIL timeout_c%0d: got %b required %b", k, a_timeout, (k == 9)); end
      end
      drive((k == 12), 64'd0, 1'b0);
      tick();
    end
    n_tests++; if (seen !== 1'b0 || a_check !== 1'b0) begin n_fail++; $display("FAIL timeout_check: got %b required 0", seen | a_check); end
    n_tests++; if (a_timeout !== 1'b1 || dut.state !== DONE)
      begin n_fail++; $display("FAIL timeout_sticky: got %b state %0d required 1/%0d", a_timeout, dut.state, DONE); end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    test_reset();
    test_capture();
    test_window_edge();
    test_order_err();
    test_order_wrap();
    test_reset_in_fire();
    test_cc0_trap();
`ifdef RISCV_FORMAL_CHECK_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
